stopwatch_ctrl: RTL and testbench

//  Sequencing controller for the 100 Hz output of the clock generator: turns that slow clock into 1-cycle ticks
//  and runs a start/pause/lap/clear FSM that gates a 4-digit BCD count (SS.CC, 00.00-59.99).

---
 rtl/stopwatch_ctrl_pkg.sv | 44 ++++
 rtl/stopwatch_ctrl_pulse_sync.sv | 44 ++++
 rtl/stopwatch_ctrl.sv | 80 ++++++++
 tb/tb_stopwatch_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch sequencing controller.
// Holds the FSM encoding, BCD digit width, parameter defaults and the BCD increment helper.
package stopwatch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_LAP   = 2'd3
   } state_t;

   localparam int BCD_W           = 4;
   localparam int SEC_MAX_DEF     = 59;
   localparam int SYNC_STAGES_DEF = 2;

   // Digit-wise increment of {sec_tens, sec_ones, cs_tens, cs_ones}; seconds wrap after max_t/max_o.
   function automatic logic [4*BCD_W-1:0] bcd_inc(input logic [4*BCD_W-1:0] c,
                                                  input logic [BCD_W-1:0]   max_t,
                                                  input logic [BCD_W-1:0]   max_o);
      logic [BCD_W-1:0] st, so, ct, co;
      {st, so, ct, co} = c;
      if (co != 4'd9) begin
         co = co + 4'd1;
      end else begin
         co = '0;
         if (ct != 4'd9) begin
            ct = ct + 4'd1;
         end else begin
            ct = '0;
            if (st == max_t && so == max_o) begin
               st = '0;
               so = '0;
            end else if (so != 4'd9) begin
               so = so + 4'd1;
            end else begin
               so = '0;
               st = st + 4'd1;
            end
         end
      end
      return {st, so, ct, co};
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_pulse_sync.sv
// Optional synchronizer chain followed by a registered rising-edge detector.
// The detector stays disarmed until the chain holds real samples, so a level high at reset release never pulses.
module pulse_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic pulse
);

   logic              d_s;
   logic              prev;
   logic [STAGES:0]   arm;

   if (STAGES == 0) begin : g_direct
      assign d_s = din;
   end else begin : g_sync
      logic [STAGES-1:0] chain;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            chain <= '0;
         end else begin
            chain[0] <= din;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
         end
      end
      assign d_s = chain[STAGES-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arm   <= '0;
         prev  <= 1'b0;
         pulse <= 1'b0;
      end else begin
         arm[0] <= 1'b1;
         for (int i = 1; i <= STAGES; i++) arm[i] <= arm[i-1];
         prev  <= d_s;
         pulse <= arm[STAGES] & d_s & ~prev;
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: converts the 100 Hz clock into ticks and runs the start/pause/lap/clear FSM
// that gates a 4-digit BCD count (SS.CC) and selects the live or lapped value for the display.
import stopwatch_ctrl_pkg::*;

module stopwatch_ctrl #(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int SEC_MAX     = SEC_MAX_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_100,
   input  logic        btn_ss,
   input  logic        btn_lr,
   output logic [15:0] disp,
   output logic        running,
   output logic        lap_active,
   output logic        wrap,
   output state_t      state
);

   localparam logic [BCD_W-1:0] MAX_T     = 4'(SEC_MAX / 10);
   localparam logic [BCD_W-1:0] MAX_O     = 4'(SEC_MAX % 10);
   localparam logic [15:0]      COUNT_MAX = {MAX_T, MAX_O, 4'd9, 4'd9};

   logic        tick;
   logic        ss_p;
   logic        lr_p;
   logic        counting;
   logic [15:0] count;
   logic [15:0] lap_reg;

   pulse_sync #(.STAGES(SYNC_STAGES)) u_tick (.clk(clk), .rst(rst), .din(clk_100), .pulse(tick));
   pulse_sync #(.STAGES(0))           u_ss   (.clk(clk), .rst(rst), .din(btn_ss),  .pulse(ss_p));
   pulse_sync #(.STAGES(0))           u_lr   (.clk(clk), .rst(rst), .din(btn_lr),  .pulse(lr_p));

   // Counting follows the current registered state, so a tick on a leaving edge counts, an entering one does not.
   assign counting   = (state == ST_RUN) || (state == ST_LAP);
   assign running    = counting;
   assign lap_active = (state == ST_LAP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         count   <= '0;
         lap_reg <= '0;
         disp    <= '0;
         wrap    <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (tick && counting) begin
            count <= bcd_inc(count, MAX_T, MAX_O);
            wrap  <= (count == COUNT_MAX);
         end

         if (ss_p) begin
            case (state)
               ST_IDLE, ST_PAUSE: state <= ST_RUN;
               ST_RUN, ST_LAP:    state <= ST_PAUSE;
               default:           state <= ST_IDLE;
            endcase
         end else if (lr_p) begin
            case (state)
               ST_RUN: begin
                  state   <= ST_LAP;
                  lap_reg <= count;
               end
               ST_LAP:   state <= ST_RUN;
               ST_PAUSE: begin
                  state <= ST_IDLE;
                  count <= '0;
               end
               default:  state <= ST_IDLE;
            endcase
         end

         disp <= (state == ST_LAP) ? lap_reg : count;
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a vector table of button/tick steps plus hand sequences
// for wrap, tick latency, coincident button/tick edges and asynchronous reset.
import stopwatch_ctrl_pkg::*;

module tb_stopwatch_ctrl;

   localparam int SYNC_STAGES = 2;

   logic        clk;
   logic        rst;
   logic        clk_100;
   logic        btn_ss;
   logic        btn_lr;
   logic [15:0] disp;
   logic        running;
   logic        lap_active;
   logic        wrap;
   state_t      state;

   int n_checks = 0;
   int n_fail   = 0;
   int wrap_cnt = 0;

   stopwatch_ctrl #(.SYNC_STAGES(SYNC_STAGES), .SEC_MAX(59)) dut (
      .clk(clk), .rst(rst), .clk_100(clk_100), .btn_ss(btn_ss), .btn_lr(btn_lr),
      .disp(disp), .running(running), .lap_active(lap_active), .wrap(wrap), .state(state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (wrap) wrap_cnt++;

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic        ss;
      logic        lr;
      int          ticks;
      logic [15:0] disp;
      logic        run;
      logic        lap;
   } vec_t;

   vec_t vecs[12];

   // checks
   task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic check_outputs(input string name, input logic [15:0] d, input logic r, input logic l);
      @(negedge clk);
      check_val({name, ".disp"}, disp, d);
      check_val({name, ".running"}, 16'(running), 16'(r));
      check_val({name, ".lap_active"}, 16'(lap_active), 16'(l));
   endtask

   // drivers
   task automatic press(input logic ss, input logic lr);
      @(posedge clk); #1;
      btn_ss = ss;
      btn_lr = lr;
      repeat (3) @(posedge clk);
      #1;
      btn_ss = 1'b0;
      btn_lr = 1'b0;
      @(posedge clk);
   endtask

   task automatic tick_100(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1 clk_100 = 1'b1;
         repeat (2) @(posedge clk);
         #1 clk_100 = 1'b0;
         repeat (2) @(posedge clk);
      end
   endtask

   // Button edge detected in the same clk cycle as the tick pulse.
   task automatic tick_with_press(input logic ss, input logic lr);
      @(posedge clk); #1 clk_100 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      clk_100 = 1'b0;
      btn_ss  = ss;
      btn_lr  = lr;
      repeat (3) @(posedge clk);
      #1;
      btn_ss = 1'b0;
      btn_lr = 1'b0;
      @(posedge clk);
   endtask

   task automatic settle();
      repeat (2) @(posedge clk);
   endtask

   initial begin
      int lat;
      bit seen;
      int wrap_before;

      rst     = 1'b1;
      clk_100 = 1'b0;
      btn_ss  = 1'b0;
      btn_lr  = 1'b0;

      vecs[0]  = '{1'b0, 1'b0, 3,    16'h0000, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 250,  16'h0250, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 5,    16'h0250, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 0,    16'h0000, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 1234, 16'h1234, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 10,   16'h1234, 1'b1, 1'b1};
      vecs[6]  = '{1'b0, 1'b1, 0,    16'h1244, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 3,    16'h1244, 1'b1, 1'b1};
      vecs[8]  = '{1'b1, 1'b0, 0,    16'h1247, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 0,    16'h0000, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 4,    16'h0000, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 5998, 16'h5998, 1'b1, 1'b0};

      repeat (3) @(posedge clk);
      check_outputs("reset", 16'h0000, 1'b0, 1'b0);
      check_val("reset.wrap", 16'(wrap), 16'h0);
      check_val("reset.state", 16'(state), 16'(ST_IDLE));
      @(posedge clk); #1 rst = 1'b0;

      for (int v = 0; v < 12; v++) begin
         if (vecs[v].ss || vecs[v].lr) press(vecs[v].ss, vecs[v].lr);
         tick_100(vecs[v].ticks);
         settle();
         check_outputs($sformatf("vec%0d", v), vecs[v].disp, vecs[v].run, vecs[v].lap);
      end
      check_val("no_early_wrap", 16'(wrap_cnt), 16'd0);

      // wrap from 59.99 to 00.00
      tick_100(1);
      settle();
      check_outputs("pre_wrap", 16'h5999, 1'b1, 1'b0);
      wrap_before = wrap_cnt;
      tick_100(1);
      settle();
      check_outputs("wrap", 16'h0000, 1'b1, 1'b0);
      check_val("wrap_width", 16'(wrap_cnt - wrap_before), 16'd1);

      // tick latency from clk_100 rising edge
      @(posedge clk); #1 clk_100 = 1'b1;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (dut.tick) seen = 1'b1;
      end
      #1 clk_100 = 1'b0;
      check_val("tick_latency", 16'(lat), 16'(SYNC_STAGES + 1));
      repeat (4) @(posedge clk);
      check_outputs("after_latency", 16'h0001, 1'b1, 1'b0);

      // stop coincident with tick: tick counted, then paused
      tick_with_press(1'b1, 1'b0);
      settle();
      check_outputs("stop_on_tick", 16'h0002, 1'b0, 1'b0);
      tick_100(5);
      settle();
      check_outputs("paused_ticks", 16'h0002, 1'b0, 1'b0);
      press(1'b0, 1'b1);
      settle();
      check_outputs("clear", 16'h0000, 1'b0, 1'b0);
      press(1'b1, 1'b0);
      tick_100(3);
      press(1'b1, 1'b0);
      settle();
      check_outputs("pause3", 16'h0003, 1'b0, 1'b0);
      press(1'b1, 1'b1);
      settle();
      check_outputs("both_btns", 16'h0003, 1'b1, 1'b0);
      tick_100(1);
      settle();
      check_outputs("both_then_tick", 16'h0004, 1'b1, 1'b0);

      // start coincident with tick: tick not counted
      press(1'b1, 1'b0);
      tick_with_press(1'b1, 1'b0);
      settle();
      check_outputs("start_on_tick", 16'h0004, 1'b1, 1'b0);
      tick_100(1);
      settle();
      check_outputs("start_then_tick", 16'h0005, 1'b1, 1'b0);

      // asynchronous reset mid-run at 33.33
      tick_100(3328);
      settle();
      check_outputs("pre_rst", 16'h3333, 1'b1, 1'b0);
      @(posedge clk); #3;
      btn_ss = 1'b1;
      rst    = 1'b1;
      #1;
      check_val("async_rst.disp", disp, 16'h0000);
      check_val("async_rst.running", 16'(running), 16'h0);
      check_val("async_rst.lap_active", 16'(lap_active), 16'h0);
      check_val("async_rst.wrap", 16'(wrap), 16'h0);
      check_val("async_rst.state", 16'(state), 16'(ST_IDLE));
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      tick_100(3);
      settle();
      check_outputs("held_btn_release", 16'h0000, 1'b0, 1'b0);
      check_val("held_btn_state", 16'(state), 16'(ST_IDLE));
      btn_ss = 1'b0;
      press(1'b1, 1'b0);
      tick_100(2);
      settle();
      check_outputs("restart", 16'h0002, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
